cp0_ctrl: RTL and testbench
===========================

CP0_CTRL -- requirements
Module: cp0_ctrl

Interface
REQ-001 Parameter HW_INT_NUM, default 6, shall set the number of hardware interrupt inputs (legal 1..6).
REQ-002 Parameter TIMER_DIV, default 2, shall set the clk cycles per Count increment (legal >=1).
REQ-003 Ports (name direction width meaning), clock and reset first:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- cp0_addr  in  8  {reg[4:0], sel[2:0]} of the accessed register.
- cp0_rdata  out  32  read data for cp0_addr.
- cp0_wen  in  1  software (mtc0) write strobe.
- cp0_wdata  in  32  software write data.
- exc_type  in  7  {int, adel, ades, sys, bp, ri, ov}, any number of bits set.
- PC  in  32  PC of the excepting instruction.
- is_slot  in  1  excepting instruction is in a delay slot.
- bad_vaddr  in  32  faulting address for adel/ades.
- int_in  in  HW_INT_NUM  level-sensitive hardware interrupt lines.
- eret  in  1  eret retiring this cycle.
- EPC  out  32  current EPC value.
- int_happen  out  1  interrupt pending and enabled.

Function
REQ-004 Implemented registers (reg number, sel 0 only): BadVAddr 8, Count 9, Compare 11, Status 12, Cause 13, EPC 14; any other reg or sel!=0 shall read 0 and ignore writes.
REQ-005 cp0_rdata shall be combinational from cp0_addr and current register state (zero read latency).
REQ-006 Status layout: bit22 BEV (read-only 1), bits15:8 IM (R/W), bit1 EXL (R/W), bit0 IE (R/W), all others 0.
REQ-007 Cause layout: bit31 BD, bit30 TI, bits15:8 IP, bits6:2 ExcCode, all others 0; only IP[1:0] software-writable.
REQ-008 IP[2+HW_INT_NUM-1:2] shall register int_in every cycle (one-cycle latency); unused IP bits shall read 0.
REQ-009 Exception priority when several exc_type bits are set: int > adel > ades > sys > bp > ri > ov; only the winner is recorded.
REQ-010 ExcCodes: int 0x00, adel 0x04, ades 0x05, sys 0x08, bp 0x09, ri 0x0a, ov 0x0c.
REQ-011 On any exception: EXL<=1 and ExcCode<=winner code; if EXL was 0 also EPC<=(is_slot ? PC-4 : PC) and BD<=is_slot; if EXL was 1, EPC and BD shall hold.
REQ-012 BadVAddr<=bad_vaddr when the winner is adel or ades; otherwise it holds.
REQ-013 eret shall clear EXL the next cycle; exception in the same cycle wins (EXL stays 1).
REQ-014 A software write in the same cycle as an exception shall be discarded entirely.
REQ-015 int_happen = !EXL && IE && |(IM & IP), bitwise AND over 8 bits.
REQ-016 A prescaler shall count 0..TIMER_DIV-1; Count shall increment by 1 when it wraps, with Count wrapping 0xFFFFFFFF->0.
REQ-017 A software write to Count shall load cp0_wdata and clear the prescaler; no increment that cycle.
REQ-018 A software write to Compare shall load cp0_wdata and clear TI; the clear wins over a same-cycle match.
REQ-019 TI shall set one cycle after Count equals Compare, then hold until the next Compare write.

Reset
REQ-020 While rst is high: BEV=1, IM=0, EXL=0, IE=0, Cause=0, EPC=0, BadVAddr=0, Count=0, Compare=0, prescaler=0; int_happen=0; cp0_rdata reflects these values.
REQ-021 Asserting rst mid-operation shall abort any pending update immediately; the first post-reset edge behaves as a fresh start.

Configuration
REQ-022 Macro CP0_TIMER_INT_EN: when defined, IP[7] = TI | (HW_INT_NUM==6 ? registered int_in[5] : 0).
REQ-023 Without CP0_TIMER_INT_EN: Count, Compare and the prescaler are absent; regs 9 and 11 read 0 and ignore writes; TI reads 0; IP[7] comes from int_in[5] only.

Verification
REQ-024 Reset release, read Status -> 0x00400000; read Cause, EPC, Count -> 0.
REQ-025 exc_type=0b0100100 (adel+bp), PC=0xBFC00100, is_slot=1, EXL=0 -> EPC=0xBFC000FC, BD=1, ExcCode=0x04, BadVAddr=bad_vaddr, EXL=1.
REQ-026 Second exception with EXL=1 (sys, PC=0x80000010) -> ExcCode=0x08, EPC and BD unchanged; then eret -> EXL=0 next cycle.
REQ-027 Write Status=0x00000401, int_in[0]=1 -> int_happen=1 two cycles later; set EXL -> int_happen=0.
REQ-028 (CP0_TIMER_INT_EN, TIMER_DIV=2) write Count=0xFFFFFFFE, Compare=0x00000000 -> Count wraps after 4 cycles, TI=1 the cycle after, IP[7]=1; write Compare -> TI=0.
REQ-029 Same-cycle mtc0 to EPC with an ov exception, EXL=0 -> EPC=PC, written data discarded, ExcCode=0x0c.

Source files
------------

// File: rtl/cp0_ctrl.sv
// CP0 control block: Status/Cause/EPC/BadVAddr, exception capture and interrupt request.
// Optional Count/Compare timer and timer interrupt on IP[7] are built when CP0_TIMER_INT_EN is defined.
module cp0_ctrl #(
    parameter int HW_INT_NUM = 6,
    parameter int TIMER_DIV  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            cp0_addr,
    output logic [31:0]           cp0_rdata,
    input  logic                  cp0_wen,
    input  logic [31:0]           cp0_wdata,
    input  logic [6:0]            exc_type,
    input  logic [31:0]           PC,
    input  logic                  is_slot,
    input  logic [31:0]           bad_vaddr,
    input  logic [HW_INT_NUM-1:0] int_in,
    input  logic                  eret,
    output logic [31:0]           EPC,
    output logic                  int_happen
);

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    typedef struct packed {
        logic       valid;
        logic [4:0] code;
        logic       bad;   // winner carries a faulting address
    } exc_t;

    logic [4:0] reg_n;
    logic       sel0;
    logic       sw_we;
    exc_t       exc;

    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [4:0]  exccode_q, exccode_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [5:0]  ip_hw_q, ip_hw_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;

    logic [5:0]  int_pad;
    logic [7:0]  ip;
    logic        ti;
    logic [31:0] count_rd, compare_rd;

    assign reg_n = cp0_addr[7:3];
    assign sel0  = (cp0_addr[2:0] == 3'd0);
    // Any exception in the cycle discards the software write in full.
    assign sw_we = cp0_wen && sel0 && !(|exc_type);

    always_comb begin
        exc = '{valid: 1'b1, code: 5'h00, bad: 1'b0};
        casez (exc_type)
            7'b1??????: exc = '{valid: 1'b1, code: 5'h00, bad: 1'b0};
            7'b01?????: exc = '{valid: 1'b1, code: 5'h04, bad: 1'b1};
            7'b001????: exc = '{valid: 1'b1, code: 5'h05, bad: 1'b1};
            7'b0001???: exc = '{valid: 1'b1, code: 5'h08, bad: 1'b0};
            7'b00001??: exc = '{valid: 1'b1, code: 5'h09, bad: 1'b0};
            7'b000001?: exc = '{valid: 1'b1, code: 5'h0a, bad: 1'b0};
            7'b0000001: exc = '{valid: 1'b1, code: 5'h0c, bad: 1'b0};
            default:    exc = '{valid: 1'b0, code: 5'h00, bad: 1'b0};
        endcase
    end

    always_comb begin
        int_pad = '0;
        int_pad[HW_INT_NUM-1:0] = int_in;
    end

    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        exccode_d  = exccode_q;
        ip_sw_d    = ip_sw_q;
        ip_hw_d    = int_pad;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;

        if (sw_we) begin
            case (reg_n)
                REG_STATUS: begin
                    im_d  = cp0_wdata[15:8];
                    exl_d = cp0_wdata[1];
                    ie_d  = cp0_wdata[0];
                end
                REG_CAUSE: ip_sw_d = cp0_wdata[9:8];
                REG_EPC:   epc_d   = cp0_wdata;
                default: ;
            endcase
        end

        if (eret)
            exl_d = 1'b0;

        if (exc.valid) begin
            exl_d     = 1'b1;
            exccode_d = exc.code;
            // Nested exceptions keep the original return point.
            if (!exl_q) begin
                epc_d = is_slot ? (PC - 32'd4) : PC;
                bd_d  = is_slot;
            end
            if (exc.bad)
                badvaddr_d = bad_vaddr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            exccode_q  <= '0;
            ip_sw_q    <= '0;
            ip_hw_q    <= '0;
            epc_q      <= '0;
            badvaddr_q <= '0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            exccode_q  <= exccode_d;
            ip_sw_q    <= ip_sw_d;
            ip_hw_q    <= ip_hw_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
        end
    end

`ifdef CP0_TIMER_INT_EN
    localparam int PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

    logic [PW-1:0] pre_q, pre_d;
    logic [31:0]   count_q, count_d;
    logic [31:0]   compare_q, compare_d;
    logic          ti_q, ti_d;

    always_comb begin
        pre_d     = pre_q;
        count_d   = count_q;
        compare_d = compare_q;
        ti_d      = ti_q | (count_q == compare_q);

        if (sw_we && reg_n == REG_COUNT) begin
            count_d = cp0_wdata;
            pre_d   = '0;
        end else if (pre_q == PW'(TIMER_DIV - 1)) begin
            pre_d   = '0;
            count_d = count_q + 32'd1;
        end else begin
            pre_d   = pre_q + PW'(1);
        end

        if (sw_we && reg_n == REG_COMPARE) begin
            compare_d = cp0_wdata;
            ti_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q     <= '0;
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            pre_q     <= pre_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign ti         = ti_q;
    assign count_rd   = count_q;
    assign compare_rd = compare_q;
`else
    assign ti         = 1'b0;
    assign count_rd   = 32'd0;
    assign compare_rd = 32'd0;
`endif

    // ip_hw_q[5] is already zero when fewer than six lines exist.
    assign ip = {ip_hw_q[5] | ti, ip_hw_q[4:0], ip_sw_q};

    assign int_happen = !exl_q && ie_q && (|(im_q & ip));
    assign EPC        = epc_q;

    always_comb begin
        cp0_rdata = 32'd0;
        if (sel0) begin
            case (reg_n)
                REG_BADVADDR: cp0_rdata = badvaddr_q;
                REG_COUNT:    cp0_rdata = count_rd;
                REG_COMPARE:  cp0_rdata = compare_rd;
                REG_STATUS:   cp0_rdata = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
                REG_CAUSE:    cp0_rdata = {bd_q, ti, 14'd0, ip, 1'b0, exccode_q, 2'b00};
                REG_EPC:      cp0_rdata = epc_q;
                default:      cp0_rdata = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_cp0_ctrl.sv
// Directed bench for cp0_ctrl: expectations queued with each stimulus step, popped and checked by immediate assertions.
module tb_cp0_ctrl;

    localparam logic [7:0] A_BADV = 8'h40;
    localparam logic [7:0] A_CNT  = 8'h48;
    localparam logic [7:0] A_CMP  = 8'h58;
    localparam logic [7:0] A_STAT = 8'h60;
    localparam logic [7:0] A_CAUS = 8'h68;
    localparam logic [7:0] A_EPC  = 8'h70;

`ifdef CP0_TIMER_INT_EN
    localparam logic [31:0] TIX = 32'h4000_8000;   // TI and IP[7] set since Count==Compare after reset
`else
    localparam logic [31:0] TIX = 32'h0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  cp0_addr;
    logic [31:0] cp0_rdata;
    logic        cp0_wen;
    logic [31:0] cp0_wdata;
    logic [6:0]  exc_type;
    logic [31:0] PC;
    logic        is_slot;
    logic [31:0] bad_vaddr;
    logic [5:0]  int_in;
    logic        eret;
    logic [31:0] EPC;
    logic        int_happen;

    cp0_ctrl #(.HW_INT_NUM(6), .TIMER_DIV(2)) dut (
        .clk(clk), .rst(rst), .cp0_addr(cp0_addr), .cp0_rdata(cp0_rdata),
        .cp0_wen(cp0_wen), .cp0_wdata(cp0_wdata), .exc_type(exc_type), .PC(PC),
        .is_slot(is_slot), .bad_vaddr(bad_vaddr), .int_in(int_in), .eret(eret),
        .EPC(EPC), .int_happen(int_happen)
    );

    always #10 clk = ~clk;

    typedef struct {
        string       tag;
        int          kind;   // 0: cp0_rdata at addr, 1: EPC port, 2: int_happen
        logic [7:0]  addr;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   nchk = 0;
    int   nfail = 0;

    task automatic exp_rd(input string tag, input logic [7:0] addr, input logic [31:0] val);
        q.push_back('{tag: tag, kind: 0, addr: addr, val: val});
    endtask

    task automatic exp_epc(input string tag, input logic [31:0] val);
        q.push_back('{tag: tag, kind: 1, addr: 8'h0, val: val});
    endtask

    task automatic exp_int(input string tag, input logic val);
        q.push_back('{tag: tag, kind: 2, addr: 8'h0, val: {31'd0, val}});
    endtask

    // Pops everything queued; at most a few checks per call so it stays inside the low clock phase.
    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (q.size() > 0) begin
            e = q.pop_front();
            if (e.kind == 0) cp0_addr = e.addr;
            #1;
            case (e.kind)
                0:       obs = cp0_rdata;
                1:       obs = EPC;
                default: obs = {31'd0, int_happen};
            endcase
            nchk++;
            assert (obs === e.val) else begin
                nfail++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] addr, input logic [31:0] data);
        cp0_wen = 1'b1; cp0_addr = addr; cp0_wdata = data;
        tick();
        cp0_wen = 1'b0;
    endtask

    task automatic exc(input logic [6:0] t, input logic [31:0] pc, input logic slot, input logic [31:0] bva);
        exc_type = t; PC = pc; is_slot = slot; bad_vaddr = bva;
        tick();
        exc_type = '0;
    endtask

    task automatic do_eret();
        eret = 1'b1;
        tick();
        eret = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cp0_addr = '0; cp0_wen = 1'b0; cp0_wdata = '0; exc_type = '0;
        PC = '0; is_slot = 1'b0; bad_vaddr = '0; int_in = '0; eret = 1'b0;

        // Reset held
        repeat (2) @(negedge clk);
        exp_rd("rst_status", A_STAT, 32'h0040_0000);
        exp_rd("rst_cause",  A_CAUS, 32'h0);
        exp_rd("rst_count",  A_CNT,  32'h0);
        exp_rd("rst_badv",   A_BADV, 32'h0);
        exp_int("rst_int", 1'b0);
        drain();

        // Reset release, before any active edge
        @(negedge clk);
        rst = 1'b0;
        exp_rd("rel_status", A_STAT, 32'h0040_0000);
        exp_rd("rel_cause",  A_CAUS, 32'h0);
        exp_rd("rel_epc",    A_EPC,  32'h0);
        exp_rd("rel_count",  A_CNT,  32'h0);
        drain();

        // adel+bp from a delay slot: adel wins
        exc(7'b0100100, 32'hBFC0_0100, 1'b1, 32'h1234_5679);
        exp_epc("a_epc", 32'hBFC0_00FC);
        exp_rd("a_cause", A_CAUS, 32'h8000_0010 | TIX);
        exp_rd("a_badv",  A_BADV, 32'h1234_5679);
        exp_rd("a_status", A_STAT, 32'h0040_0002);
        drain();

        // Nested sys with EXL=1: code changes, EPC/BD/BadVAddr hold
        exc(7'b0001000, 32'h8000_0010, 1'b0, 32'hDEAD_0000);
        exp_epc("b_epc", 32'hBFC0_00FC);
        exp_rd("b_cause", A_CAUS, 32'h8000_0020 | TIX);
        exp_rd("b_badv",  A_BADV, 32'h1234_5679);
        drain();

        do_eret();
        exp_rd("c_status", A_STAT, 32'h0040_0000);
        drain();

        // eret together with ri: exception wins
        eret = 1'b1;
        exc(7'b0000010, 32'h8000_0100, 1'b0, 32'h0);
        eret = 1'b0;
        exp_rd("d_status", A_STAT, 32'h0040_0002);
        exp_rd("d_cause",  A_CAUS, 32'h0000_0028 | TIX);
        exp_epc("d_epc", 32'h8000_0100);
        drain();
        do_eret();

        // mtc0 EPC in the same cycle as ov: write discarded
        cp0_wen = 1'b1; cp0_addr = A_EPC; cp0_wdata = 32'h1111_1111;
        exc(7'b0000001, 32'h8000_0200, 1'b0, 32'h0);
        cp0_wen = 1'b0;
        exp_epc("e_epc", 32'h8000_0200);
        exp_rd("e_cause", A_CAUS, 32'h0000_0030 | TIX);
        exp_rd("e_status", A_STAT, 32'h0040_0002);
        drain();
        do_eret();

        // Plain software writes, unimplemented reg, non-zero sel
        wr(A_EPC, 32'hA5A5_A5A0);
        wr(8'h78, 32'hFFFF_FFFF);
        wr(8'h61, 32'hFFFF_FFFF);
        exp_epc("f_epc", 32'hA5A5_A5A0);
        exp_rd("f_rd_epc", A_EPC, 32'hA5A5_A5A0);
        exp_rd("f_unimpl", 8'h78, 32'h0);
        exp_rd("f_sel1_rd", 8'h61, 32'h0);
        exp_rd("f_sel1_wr", A_STAT, 32'h0040_0000);
        drain();

        // All bits set: int wins, no BadVAddr update
        exc(7'h7F, 32'h8000_0300, 1'b1, 32'h0BAD_0000);
        exp_rd("g_cause", A_CAUS, 32'h8000_0000 | TIX);
        exp_epc("g_epc", 32'h8000_02FC);
        exp_rd("g_badv", A_BADV, 32'h1234_5679);
        drain();
        do_eret();

        // ades beats sys
        exc(7'b0011000, 32'h8000_0400, 1'b0, 32'h0BAD_0000);
        exp_rd("h_cause", A_CAUS, 32'h0000_0014 | TIX);
        exp_rd("h_badv",  A_BADV, 32'h0BAD_0000);
        exp_epc("h_epc", 32'h8000_0400);
        drain();
        do_eret();

        // Hardware interrupt path
        wr(A_STAT, 32'h0000_0401);
        int_in = 6'b000001;
        exp_rd("i_status", A_STAT, 32'h0040_0401);
        exp_int("i_int_pre", 1'b0);
        drain();
        tick();
        exp_int("i_int_post", 1'b1);
        exp_rd("i_cause", A_CAUS, 32'h0000_0414 | TIX);
        drain();
        wr(A_STAT, 32'h0000_0403);
        exp_int("i_int_exl", 1'b0);
        drain();

        // Software IP bits, masked by IM
        wr(A_CAUS, 32'hFFFF_FFFF);
        exp_rd("j_cause", A_CAUS, 32'h0000_0714 | TIX);
        drain();
        wr(A_STAT, 32'h0000_0101);
        exp_int("j_int_sw", 1'b1);
        drain();
        int_in = '0;
        wr(A_CAUS, 32'h0);
        exp_int("j_int_clr", 1'b0);
        exp_rd("j_cause0", A_CAUS, 32'h0000_0014 | TIX);
        drain();

`ifdef CP0_TIMER_INT_EN
        wr(A_CNT, 32'hFFFF_FFFE);
        wr(A_CMP, 32'h0000_0000);
        exp_rd("t_cnt0", A_CNT, 32'hFFFF_FFFE);
        exp_rd("t_ti0", A_CAUS, 32'h0000_0014);
        drain();
        tick();
        exp_rd("t_cnt1", A_CNT, 32'hFFFF_FFFF);
        drain();
        tick();
        tick();
        exp_rd("t_cnt_wrap", A_CNT, 32'h0);
        exp_rd("t_ti_pre", A_CAUS, 32'h0000_0014);
        drain();
        tick();
        exp_rd("t_ti_set", A_CAUS, 32'h4000_8014);
        drain();
        wr(A_CMP, 32'h0000_0100);
        exp_rd("t_ti_clr", A_CAUS, 32'h0000_0014);
        exp_rd("t_cmp", A_CMP, 32'h0000_0100);
        drain();
`else
        wr(A_CNT, 32'h0000_0005);
        wr(A_CMP, 32'h0000_0005);
        exp_rd("t_cnt_absent", A_CNT, 32'h0);
        exp_rd("t_cmp_absent", A_CMP, 32'h0);
        drain();
`endif

        // Mid-operation asynchronous reset
        wr(A_STAT, 32'h0000_FF03);
        #2 rst = 1'b1;
        exp_rd("r_status", A_STAT, 32'h0040_0000);
        exp_rd("r_cause",  A_CAUS, 32'h0);
        exp_epc("r_epc", 32'h0);
        exp_rd("r_badv",   A_BADV, 32'h0);
        exp_int("r_int", 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
